// File: rtl/checkpoint_seq_monitor_pkg.sv
// -----------------------------------------------------------------------------
// checkpoint_mon_pkg
// Shared types and constants for the checkpoint sequence monitor.
//   mon_state_t       : monitor state (IDLE, ARMED and the three terminal states)
//   DEFAULT_FAIL_CODE : code firmware drives to flag an explicit failure
// -----------------------------------------------------------------------------
package checkpoint_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_t;

    localparam logic [15:0] DEFAULT_FAIL_CODE = 16'hDEAD;

endpackage

// File: rtl/checkpoint_seq_monitor_if.sv
// -----------------------------------------------------------------------------
// checkpoint_seq_monitor_if
// Bundles the control, code and status signals of the checkpoint monitor.
//   start      : single-cycle arm pulse
//   exp_codes  : expected codes, code j at [j*CHECK_W +: CHECK_W]
//   checkbits  : observed checkpoint field
//   stage      : checkpoints matched so far
//   busy       : high while armed
//   pass/fail/timeout : sticky verdict flags
//   fail_info  : value that caused a failure, 0 otherwise
// Modports: master drives stimulus and observes status, slave is the monitor.
// -----------------------------------------------------------------------------
interface checkpoint_seq_monitor_if #(
    parameter int CHECK_W    = 16,
    parameter int NUM_CHECKS = 2,
    parameter int IDX_W      = $clog2(NUM_CHECKS + 1)
);
    logic                          start;
    logic [NUM_CHECKS*CHECK_W-1:0] exp_codes;
    logic [CHECK_W-1:0]            checkbits;
    logic [IDX_W-1:0]              stage;
    logic                          busy;
    logic                          pass;
    logic                          fail;
    logic                          timeout;
    logic [CHECK_W-1:0]            fail_info;

    modport master (
        output start, exp_codes, checkbits,
        input  stage, busy, pass, fail, timeout, fail_info
    );

    modport slave (
        input  start, exp_codes, checkbits,
        output stage, busy, pass, fail, timeout, fail_info
    );
endinterface

// File: rtl/checkpoint_seq_monitor_filter.sv
// -----------------------------------------------------------------------------
// checkbits_stable_filter
// Samples the checkpoint field every cycle and raises a one-shot eval strobe
// once per stable episode, in the first cycle the sampled value has been held
// for STABLE_CYCLES consecutive samples.
//   clock, resetb : clock and asynchronous active-low reset
//   restart       : begin a fresh episode on the value now being sampled
//   checkbits     : raw observed field
//   value         : sampled value (valid when eval is high)
//   eval          : one-shot evaluation strobe
// -----------------------------------------------------------------------------
module checkbits_stable_filter #(
    parameter int CHECK_W       = 16,
    parameter int STABLE_CYCLES = 1
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               restart,
    input  logic [CHECK_W-1:0] checkbits,
    output logic [CHECK_W-1:0] value,
    output logic               eval
);
    localparam int              HOLD_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_CYCLES);

    logic [CHECK_W-1:0] chk_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               evaluated;

    // hold_cnt saturates, so the evaluated flag is what keeps the strobe one-shot
    assign eval  = (hold_cnt == HOLD_MAX) && !evaluated;
    assign value = chk_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            chk_q     <= '0;
            hold_cnt  <= '0;
            evaluated <= 1'b0;
        end else begin
            chk_q <= checkbits;
            // A new sample (or a re-arm) opens a new episode of length 1
            if (restart || (checkbits != chk_q)) begin
                hold_cnt  <= HOLD_W'(1);
                evaluated <= 1'b0;
            end else begin
                if (hold_cnt != HOLD_MAX)
                    hold_cnt <= hold_cnt + 1'b1;
                if (eval)
                    evaluated <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/checkpoint_seq_monitor.sv
// -----------------------------------------------------------------------------
// checkpoint_seq_monitor
// Tracks an ordered sequence of firmware checkpoint codes on a GPIO field and
// reports pass, fail (explicit fail code or out-of-order checkpoint) or
// timeout.
//   clock  : rising-edge clock
//   resetb : asynchronous active-low reset
//   bus    : slave modport of checkpoint_seq_monitor_if (start, exp_codes,
//            checkbits in; stage, busy, pass, fail, timeout, fail_info out)
// -----------------------------------------------------------------------------
module checkpoint_seq_monitor
    import checkpoint_mon_pkg::*;
#(
    parameter int                 CHECK_W        = 16,
    parameter int                 NUM_CHECKS     = 2,
    parameter int                 STABLE_CYCLES  = 1,
    parameter int                 TIMEOUT_CYCLES = 220000,
    parameter logic [CHECK_W-1:0] FAIL_CODE      = CHECK_W'(DEFAULT_FAIL_CODE),
    parameter int                 CNT_W          = 18,
    parameter int                 IDX_W          = $clog2(NUM_CHECKS + 1)
) (
    input logic                   clock,
    input logic                   resetb,
    checkpoint_seq_monitor_if.slave bus
);
    mon_state_t          state, state_nxt;
    logic [IDX_W-1:0]    stage, stage_nxt;
    logic [CHECK_W-1:0]  fail_info, fail_info_nxt;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [CHECK_W-1:0]  value;
    logic                eval;
    logic [NUM_CHECKS-1:0] at_stage, ahead;
    logic                hit_cur, hit_skip, last_stage, tmo_expire;

    checkbits_stable_filter #(
        .CHECK_W       (CHECK_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock     (clock),
        .resetb    (resetb),
        .restart   (bus.start),
        .checkbits (bus.checkbits),
        .value     (value),
        .eval      (eval)
    );

    // Per-code comparators: the code at the current stage, or any later code
    for (genvar j = 0; j < NUM_CHECKS; j++) begin : g_cmp
        logic code_eq;
        assign code_eq     = (value == bus.exp_codes[j*CHECK_W +: CHECK_W]);
        assign at_stage[j] = code_eq && (stage == IDX_W'(j));
        assign ahead[j]    = code_eq && (stage <  IDX_W'(j));
    end

    assign hit_cur    = |at_stage;
    assign hit_skip   = |ahead;
    assign last_stage = (stage == IDX_W'(NUM_CHECKS - 1));
    assign tmo_expire = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Start always wins; in ARMED a final match beats timeout, and so does a fail
    always_comb begin
        state_nxt     = state;
        stage_nxt     = stage;
        fail_info_nxt = fail_info;
        if (bus.start) begin
            state_nxt     = ST_ARMED;
            stage_nxt     = '0;
            fail_info_nxt = '0;
        end else if (state == ST_ARMED) begin
            if (eval && hit_cur) begin
                stage_nxt = stage + 1'b1;
                if (last_stage)
                    state_nxt = ST_PASS;
                else if (tmo_expire)
                    state_nxt = ST_TIMEOUT;
            end else if (eval && ((value == FAIL_CODE) || hit_skip)) begin
                state_nxt     = ST_FAIL;
                fail_info_nxt = value;
            end else if (tmo_expire) begin
                state_nxt = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        bus.busy    = 1'b0;
        bus.pass    = 1'b0;
        bus.fail    = 1'b0;
        bus.timeout = 1'b0;
        case (state)
            ST_ARMED:   bus.busy    = 1'b1;
            ST_PASS:    bus.pass    = 1'b1;
            ST_FAIL:    bus.fail    = 1'b1;
            ST_TIMEOUT: bus.timeout = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            stage     <= '0;
            fail_info <= '0;
            tmo_cnt   <= '0;
        end else begin
            stage     <= stage_nxt;
            fail_info <= fail_info_nxt;
            // Counter freezes at expiry and in every non-armed state
            if (bus.start)
                tmo_cnt <= '0;
            else if ((state == ST_ARMED) && !tmo_expire)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.stage     = stage;
    assign bus.fail_info = fail_info;
endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
- Synthesizable monitor that tracks an ordered sequence of checkpoint codes driven by firmware onto a GPIO checkbits field (e.g. mprj_io[31:16]).
- Reports pass, fail or timeout.
- Parametrised successor of the single start/pass-code wait used in per-test benches: N checkpoints, configurable width, debounce, explicit fail code and a cycle-accurate timeout.
- Instantiated in DV benches alongside the caravel top, or on-chip as a self-test observer in the user project area.

Parameters:
CHECK_W, 16, width of checkbits and of each expected code
NUM_CHECKS, 2, number of ordered checkpoints (min 1)
STABLE_CYCLES, 1, consecutive sampled cycles a value must hold before it is evaluated (min 1)
TIMEOUT_CYCLES, 220000, cycles after arming before timeout (min 2)
FAIL_CODE, 16'hDEAD, code firmware drives to signal an explicit failure
CNT_W, 18, timeout counter width; must satisfy 2**CNT_W >= TIMEOUT_CYCLES
IDX_W, $clog2(NUM_CHECKS+1), stage index width (derived)

Ports:
clock  in  1  single clock, rising edge
resetb  in  1  reset, asynchronous assert, active-low
start  in  1  single-cycle arm pulse
exp_codes  in  NUM_CHECKS*CHECK_W  expected codes; code j at [j*CHECK_W +: CHECK_W]; static while armed
checkbits  in  CHECK_W  observed checkpoint field (asynchronous to firmware, synchronous to clock)
stage  out  IDX_W  number of checkpoints matched so far
busy  out  1  high while ARMED
pass  out  1  sticky, all checkpoints matched in order
fail  out  1  sticky, FAIL_CODE seen or out-of-order checkpoint
timeout  out  1  sticky, TIMEOUT_CYCLES elapsed without pass
fail_info  out  CHECK_W  stable value that caused fail (0 otherwise)

Behaviour:
- Reset (resetb low, asynchronous): state IDLE; stage, busy, pass, fail, timeout, fail_info, counters and the sample register all 0.
- Sampling: chk_q <= checkbits every cycle. hold_cnt counts consecutive cycles chk_q is unchanged; it saturates at STABLE_CYCLES and clears to 1 on change.
- Evaluation: value v = chk_q is evaluated once per stable episode, in the first cycle hold_cnt reaches STABLE_CYCLES. It is not re-evaluated until chk_q changes.
- Latency: checkbits change at edge k produces an effect at edge k+1+STABLE_CYCLES.
- States:
  - IDLE: outputs hold. start -> ARMED, clearing stage, pass, fail, timeout, fail_info and the timeout counter. Episode tracking also restarts, so a value already on checkbits is evaluated afresh.
  - ARMED: busy=1; timeout counter increments each cycle. On evaluation of v, priority order:
    1. v == exp[stage]: stage+1; if that was the last stage -> PASS.
    2. v == FAIL_CODE -> FAIL, fail_info=v.
    3. v == exp[j] for some j > stage -> FAIL (skip), fail_info=v.
    4. Otherwise ignored (idle values, earlier codes).
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 in ARMED -> TIMEOUT.
  - PASS / FAIL / TIMEOUT: terminal, busy=0, flags sticky; only start (re-arm) or reset leaves them.
- Simultaneous events:
  - Final-stage match and timeout expiry in the same cycle -> PASS.
  - Fail evaluation and timeout in the same cycle -> FAIL.
  - start while ARMED -> full re-arm; the in-flight evaluation is discarded.
- Duplicate consecutive expected codes: each needs its own stable episode, so checkbits must change away and back.
- Exactly one of pass/fail/timeout is high in a terminal state; none in IDLE after reset or in ARMED.
- Counters never wrap: the timeout counter stops in terminal states, and stage saturates at NUM_CHECKS.

Decomposition:
- Package checkpoint_mon_pkg: state enum (IDLE, ARMED, PASS, FAIL, TIMEOUT) and the default FAIL_CODE constant.
- Sub-module checkbits_stable_filter: owns chk_q, hold_cnt and the one-shot eval strobe (parameters CHECK_W, STABLE_CYCLES; outputs value and eval).
- Top level holds the FSM, stage index, timeout counter and skip comparator (a generate loop over j).

Test Plan:
- NUM_CHECKS=2, exp={AB61,AB60}, start, drive 0000 -> AB60 -> AB61 -> stage 0->1->2, pass=1 at edge k+2 after AB61 (STABLE=1), busy=0.
- Same config, drive AB61 before AB60 -> fail=1, fail_info=AB61, stage=0.
- Drive DEAD after AB60 -> fail=1, fail_info=DEAD, stage=1.
- TIMEOUT_CYCLES=100, no codes driven -> timeout=1 exactly 100 cycles after the start edge.
- Final match on the same cycle as timeout expiry -> pass=1, timeout=0.
- STABLE_CYCLES=3, pulse AB60 for 2 cycles then 0000 -> no stage change; hold 3 cycles -> stage=1. Also assert resetb low mid-ARMED -> all outputs 0 immediately.
